// File: rtl/lzc_pkg.sv
// Shared types and constants for the sequential leading-zero counter / normalizer.
package lzc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } lzc_state_t;

  localparam int NIB_W = 4;

  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lzd_nibble.sv
// Combinational 4-bit leading-zero detector built from two 2-bit halves.
module lzd_nibble (
  input  logic [3:0] nib,
  output logic       nz,
  output logic [1:0] pos
);

  logic upper_nz;
  logic lower_nz;
  logic upper_pos;
  logic lower_pos;

  assign upper_nz  = |nib[3:2];
  assign lower_nz  = |nib[1:0];
  assign upper_pos = ~nib[3];
  assign lower_pos = ~nib[1];

  // Upper half wins whenever it holds a one; otherwise two zeros are already counted.
  assign nz     = upper_nz | lower_nz;
  assign pos[1] = ~upper_nz;
  assign pos[0] = upper_nz ? upper_pos : lower_pos;

endmodule

// File: rtl/lzc_norm_seq.sv
// Multi-cycle leading-zero counter and left normalizer, one nibble scanned per cycle, MSB first.
// Optional macro LZC_BACK_TO_BACK_EN lets a new operand be accepted in DONE alongside the output handshake.
module lzc_norm_seq
  import lzc_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CW    = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_zero
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  lzc_state_t       state;
  lzc_state_t       state_next;
  logic [WIDTH-1:0] operand;
  logic [CW-1:0]    count;
  logic [IW-1:0]    idx;
  logic [NIB_W-1:0] nibs [NIB];
  logic [NIB_W-1:0] cur_nib;
  logic             nz;
  logic [1:0]       pos;
  logic [CW-1:0]    shamt;
  logic             accept;

  always_comb begin
    for (int i = 0; i < NIB; i++) begin
      nibs[i] = operand[i*NIB_W +: NIB_W];
    end
  end

  assign cur_nib = nibs[idx];

  lzd_nibble u_lzd (
    .nib (cur_nib),
    .nz  (nz),
    .pos (pos)
  );

  assign shamt  = count + CW'(pos);
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SCAN;
      end
      SCAN: begin
        if (nz || idx == '0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
`ifdef LZC_BACK_TO_BACK_EN
        in_ready = out_ready;
`else
        in_ready = 1'b0;
`endif
        if (out_ready) state_next = (in_valid && in_ready) ? SCAN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The barrel shift only lands in the output register on the terminating SCAN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      operand   <= '0;
      count     <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_zero  <= 1'b0;
    end else if (accept) begin
      operand <= in_data;
      count   <= '0;
      idx     <= IW'(NIB - 1);
    end else if (state == SCAN) begin
      if (nz) begin
        out_count <= shamt;
        out_data  <= operand << shamt;
        out_zero  <= 1'b0;
      end else if (idx == '0) begin
        out_count <= CW'(WIDTH);
        out_data  <= '0;
        out_zero  <= 1'b1;
      end else begin
        count <= count + CW'(NIB_W);
        idx   <= idx - IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_lzc_norm_seq.sv
// Self-checking bench for lzc_norm_seq: directed vectors plus a cycle-level reference model.
module tb_lzc_norm_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
  localparam int CW    = $clog2(WIDTH + 1);
`ifdef LZC_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_count;
  logic             out_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  bit started  = 1'b0;

  // Reference model state: countdown to result, pending result values
  int               m_left  = 0;
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  int               m_count = 0;
  logic             m_zero  = 1'b0;

  lzc_norm_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int ref_clz(input logic [WIDTH-1:0] x);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i]) return WIDTH - 1 - i;
    end
    return WIDTH;
  endfunction

  function automatic int ref_latency(input int z);
    return (z == WIDTH) ? NIB : (z / 4) + 1;
  endfunction

  function automatic logic model_ready();
    return (m_left == 0) && (!m_valid || (B2B && out_ready));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_left  = 0;
    end else begin
      automatic logic acc = in_valid && model_ready();
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_valid = 1'b1;
      end
      if (acc) begin
        automatic int z = ref_clz(in_data);
        m_count = z;
        m_zero  = (z == WIDTH);
        m_data  = (z == WIDTH) ? '0 : (in_data << z);
        m_left  = ref_latency(z);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (started) begin
      chk("model in_ready", 32'(in_ready), 32'(model_ready()));
      chk("model out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid && out_valid) begin
        chk("model out_data", 32'(out_data), 32'(m_data));
        chk("model out_count", 32'(out_count), 32'(m_count));
        chk("model out_zero", 32'(out_zero), 32'(m_zero));
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge with in_valid dropped.
  task automatic applyStimulus(input logic [WIDTH-1:0] d);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("accept timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 16'hFFFF);
  endtask

  task automatic checkOutput(input string name, input int exp_count,
                             input logic [WIDTH-1:0] exp_data, input logic exp_zero,
                             input int exp_lat);
    int waited = 0;
    while (!out_valid && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    chk({name, " out_valid"}, 32'(out_valid), 32'd1);
    chk({name, " latency"}, 32'(cyc - acc_cyc), 32'(exp_lat));
    chk({name, " out_count"}, 32'(out_count), 32'(exp_count));
    chk({name, " out_data"}, 32'(out_data), 32'(exp_data));
    chk({name, " out_zero"}, 32'(out_zero), 32'(exp_zero));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] vec_in  [3];
    int               vec_cnt [3];
    logic [WIDTH-1:0] vec_out [3];
    int acc_first;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_count", 32'(out_count), 32'd0);
    chk("reset out_zero", 32'(out_zero), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    rst     = 1'b0;
    started = 1'b1;

    chk("ref_clz 00A3", 32'(ref_clz(16'h00A3)), 32'd8);
    chk("ref_clz 0400", 32'(ref_clz(16'h0400)), 32'd5);
    chk("ref_clz 0000", 32'(ref_clz(16'h0000)), 32'd16);
    chk("ref_latency 0001", 32'(ref_latency(15)), 32'd4);

    applyStimulus(16'h8000);
    checkOutput("msb set", 0, 16'h8000, 1'b0, 1);
    applyStimulus(16'h0001);
    checkOutput("lsb set", 15, 16'h8000, 1'b0, 4);
    applyStimulus(16'h0000);
    checkOutput("all zero", 16, 16'h0000, 1'b1, 4);

    vec_in[0] = 16'h0F00; vec_cnt[0] = 4;  vec_out[0] = 16'hF000;
    vec_in[1] = 16'h1234; vec_cnt[1] = 3;  vec_out[1] = 16'h91A0;
    vec_in[2] = 16'h0030; vec_cnt[2] = 10; vec_out[2] = 16'hC000;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vec_in[i]);
      checkOutput($sformatf("vec%0d", i), vec_cnt[i], vec_out[i], 1'b0, vec_cnt[i] / 4 + 1);
    end

    // Result must hold steady while the consumer stalls.
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(16'h00A3);
    checkOutput("stall", 8, 16'hA300, 1'b0, 3);
    repeat (5) begin
      @(negedge clk);
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall out_data", 32'(out_data), 32'hA300);
      chk("stall in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post-stall out_valid", 32'(out_valid), 32'd0);
    chk("post-stall in_ready", 32'(in_ready), 32'd1);

    applyStimulus(16'h0001);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-scan reset out_valid", 32'(out_valid), 32'd0);
    chk("mid-scan reset in_ready", 32'(in_ready), 32'd1);
    chk("mid-scan reset out_count", 32'(out_count), 32'd0);
    applyStimulus(16'h0400);
    checkOutput("after reset", 5, 16'h8000, 1'b0, 2);

    @(negedge clk);
    applyStimulus(16'h4000);
    acc_first = acc_cyc;
    checkOutput("b2b first", 1, 16'h8000, 1'b0, 1);
    applyStimulus(16'h2000);
    chk("b2b accept spacing", 32'(acc_cyc - acc_first), B2B ? 32'd2 : 32'd3);
    checkOutput("b2b second", 2, 16'h8000, 1'b0, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
